facto_core_x: RTL and testbench

- Parametrised successor of the team's memory-mapped factorial core.
- Slave register interface: operand, start/clear, interrupt enable, status, and a multi-word result.
- Generalised over bus width and result width (RES_WORDS words).
- Adds a double-factorial mode, a sticky overflow flag with early termination, and a readable status register.
- Sits on the system slave bus; its interrupt goes to the host.

---
 rtl/facto_core_x.sv | 169 ++++++++++++++++
 tb/tb_facto_core_x.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/facto_core_x.sv
// Memory-mapped factorial / double-factorial engine with a multi-word result,
// a sticky overflow flag that stops the calculation early, and a done interrupt.
module facto_core_x #(
  parameter int                DATA_W    = 64,
  parameter int                RES_WORDS = 2,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h7000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] s_dout,
  output logic              interrupt
);

  localparam int RES_W  = DATA_W * RES_WORDS;
  localparam int PROD_W = RES_W + DATA_W;

  localparam logic [7:0] OFF_OPSTART = 8'h00;
  localparam logic [7:0] OFF_OPCLEAR = 8'h08;
  localparam logic [7:0] OFF_INTR_EN = 8'h10;
  localparam logic [7:0] OFF_STATUS  = 8'h18;
  localparam logic [7:0] OFF_OPERAND = 8'h20;
  localparam logic [7:0] OFF_MODE    = 8'h28;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_operand;
  logic                r_mode;
  logic                r_intr_en;
  logic [RES_W-1:0]    r_result;
  logic [DATA_W-1:0]   r_counter;
  logic                r_step_two;
  logic                r_done;
  logic                r_ovf;

  logic                w_hit;
  logic [7:0]          w_off;
  logic                w_wr;
  logic                w_wr_start;
  logic                w_wr_clear;
  logic                w_wr_intr;
  logic                w_wr_operand;
  logic                w_wr_mode;
  logic                w_busy;
  logic [PROD_W-1:0]   w_product;
  logic [DATA_W-1:0]   w_step;
  logic [DATA_W-1:0]   w_step_p2;
  logic [DATA_W-1:0]   w_rd_data;
  logic [DATA_W-1:0]   w_res_word [4];

  assign w_hit        = (s_addr[ADDR_W-1:8] == BASE_ADDR[ADDR_W-1:8]);
  assign w_off        = s_addr[7:0];
  assign w_wr         = s_sel & s_wr & w_hit;
  assign w_wr_start   = w_wr & (w_off == OFF_OPSTART) & s_din[0];
  assign w_wr_clear   = w_wr & (w_off == OFF_OPCLEAR) & s_din[0];
  assign w_wr_intr    = w_wr & (w_off == OFF_INTR_EN);
  assign w_wr_operand = w_wr & (w_off == OFF_OPERAND);
  assign w_wr_mode    = w_wr & (w_off == OFF_MODE);
  assign w_busy       = (r_state == S_CALC);

  // Full-width product: the bits above RES_W are the overflow indicator.
  assign w_product = PROD_W'(r_result) * PROD_W'(r_counter);
  assign w_step    = r_step_two ? DATA_W'(2) : DATA_W'(1);
  assign w_step_p2 = r_step_two ? DATA_W'(4) : DATA_W'(3);

  assign interrupt = r_done & r_intr_en;

  for (genvar k = 0; k < 4; k++) begin : g_word
    if (k < RES_WORDS) begin : g_on
      assign w_res_word[k] = r_result[k*DATA_W +: DATA_W];
    end else begin : g_off
      assign w_res_word[k] = {DATA_W{1'b0}};
    end
  end

  // Read mux; result words sit at 0x40 + 8k, absent words read as zero.
  always_comb begin
    w_rd_data = {DATA_W{1'b0}};
    case (w_off)
      OFF_INTR_EN: w_rd_data = {{(DATA_W-1){1'b0}}, r_intr_en};
      OFF_STATUS:  w_rd_data = {{(DATA_W-3){1'b0}}, r_ovf, w_busy, r_done};
      OFF_OPERAND: w_rd_data = r_operand;
      OFF_MODE:    w_rd_data = {{(DATA_W-1){1'b0}}, r_mode};
      default: begin
        if ((w_off[7:5] == 3'b010) && (w_off[2:0] == 3'b000)) begin
          w_rd_data = w_res_word[w_off[4:3]];
        end else begin
          w_rd_data = {DATA_W{1'b0}};
        end
      end
    endcase
    if (s_sel && !s_wr && w_hit) begin
      s_dout = w_rd_data;
    end else begin
      s_dout = {DATA_W{1'b0}};
    end
  end

  // Control FSM with its datapath and configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_operand  <= {DATA_W{1'b0}};
      r_mode     <= 1'b0;
      r_intr_en  <= 1'b0;
      r_result   <= RES_W'(1);
      r_counter  <= {DATA_W{1'b0}};
      r_step_two <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_wr_intr) begin
        r_intr_en <= s_din[0];
      end
      if (w_wr_clear) begin
        r_state   <= S_IDLE;
        r_result  <= RES_W'(1);
        r_counter <= {DATA_W{1'b0}};
        r_done    <= 1'b0;
        r_ovf     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (w_wr_operand) begin
              r_operand <= s_din;
            end
            if (w_wr_mode) begin
              r_mode <= s_din[0];
            end
            if (w_wr_start) begin
              r_result   <= RES_W'(1);
              r_counter  <= r_operand;
              r_step_two <= r_mode;
              r_ovf      <= 1'b0;
              r_done     <= 1'b0;
              r_state    <= S_CALC;
            end
          end
          S_CALC: begin
            if (r_counter <= DATA_W'(1)) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_result  <= w_product[RES_W-1:0];
              r_counter <= (r_counter < w_step_p2) ? DATA_W'(1) : (r_counter - w_step);
              // Overflow ends the run at once, keeping the truncated product.
              if (|w_product[PROD_W-1:RES_W]) begin
                r_ovf   <= 1'b1;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_facto_core_x.sv
// Directed self-checking bench for facto_core_x (DATA_W=64, RES_WORDS=2).
module tb_facto_core_x;

  localparam logic [15:0] BASE        = 16'h7000;
  localparam logic [7:0]  OFF_OPSTART = 8'h00;
  localparam logic [7:0]  OFF_OPCLEAR = 8'h08;
  localparam logic [7:0]  OFF_INTR_EN = 8'h10;
  localparam logic [7:0]  OFF_STATUS  = 8'h18;
  localparam logic [7:0]  OFF_OPERAND = 8'h20;
  localparam logic [7:0]  OFF_MODE    = 8'h28;
  localparam logic [7:0]  OFF_RES0    = 8'h40;
  localparam logic [7:0]  OFF_RES1    = 8'h48;

  logic        clk;
  logic        reset;
  logic        s_sel;
  logic        s_wr;
  logic [15:0] s_addr;
  logic [63:0] s_din;
  logic [63:0] s_dout;
  logic        interrupt;

  int checks;
  int failures;

  facto_core_x #(
    .DATA_W(64), .RES_WORDS(2), .ADDR_W(16), .BASE_ADDR(16'h7000)
  ) dut (
    .clk(clk), .reset(reset), .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr),
    .s_din(s_din), .s_dout(s_dout), .interrupt(interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_write(input logic [15:0] addr, input logic [63:0] data);
    @(negedge clk);
    s_sel = 1'b1; s_wr = 1'b1; s_addr = addr; s_din = data;
    @(posedge clk);
    #1;
    s_sel = 1'b0; s_wr = 1'b0; s_din = 64'd0;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [63:0] data);
    s_sel = 1'b1; s_wr = 1'b0; s_addr = addr;
    #1;
    data = s_dout;
    s_sel = 1'b0;
  endtask

  task automatic read_result(output logic [127:0] res);
    logic [63:0] lo, hi;
    bus_read(BASE | OFF_RES0, lo);
    bus_read(BASE | OFF_RES1, hi);
    res = {hi, lo};
  endtask

  // Counts edges after the start edge until STATUS.done is seen; max+1 on timeout.
  task automatic wait_done(input int max_edges, output int edges);
    logic [63:0] st;
    edges = max_edges + 1;
    for (int e = 1; e <= max_edges; e++) begin
      @(posedge clk);
      #1;
      bus_read(BASE | OFF_STATUS, st);
      if (st[0]) begin
        edges = e;
        break;
      end
    end
    if (edges > max_edges) $display("FAIL wait_done timeout after %0d edges", max_edges);
  endtask

  task automatic test_reset();
    logic [63:0] d;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checks++; if (s_dout !== 64'd0) begin failures++; $display("FAIL reset_dout got=%h exp=0", s_dout); end
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL reset_intr got=%b exp=0", interrupt); end
    bus_read(BASE | OFF_STATUS, d);
    checks++; if (d !== 64'd0) begin failures++; $display("FAIL reset_status got=%h exp=0", d); end
    bus_read(BASE | OFF_RES0, d);
    checks++; if (d !== 64'd1) begin failures++; $display("FAIL reset_res0 got=%h exp=1", d); end
    bus_read(BASE | OFF_RES1, d);
    checks++; if (d !== 64'd0) begin failures++; $display("FAIL reset_res1 got=%h exp=0", d); end
    bus_read(BASE | OFF_OPERAND, d);
    checks++; if (d !== 64'd0) begin failures++; $display("FAIL reset_operand got=%h exp=0", d); end
  endtask

  task automatic test_map();
    logic [63:0] d;
    bus_write(BASE | OFF_OPERAND, 64'd9);
    bus_write(16'h7120, 64'd55);
    bus_write(BASE | 16'h0030, 64'd77);
    bus_read(BASE | OFF_OPERAND, d);
    checks++; if (d !== 64'd9) begin failures++; $display("FAIL map_operand got=%h exp=9", d); end
    bus_read(16'h7120, d);
    checks++; if (d !== 64'd0) begin failures++; $display("FAIL map_nodecode got=%h exp=0", d); end
    bus_read(BASE | 16'h0030, d);
    checks++; if (d !== 64'd0) begin failures++; $display("FAIL map_unmapped got=%h exp=0", d); end
    bus_read(BASE | 16'h0050, d);
    checks++; if (d !== 64'd0) begin failures++; $display("FAIL map_res2 got=%h exp=0", d); end
    bus_read(BASE | OFF_OPSTART, d);
    checks++; if (d !== 64'd0) begin failures++; $display("FAIL map_opstart_rd got=%h exp=0", d); end
  endtask

  task automatic test_fact5();
    logic [63:0] d;
    logic [127:0] r;
    int e;
    bus_write(BASE | OFF_OPERAND, 64'd5);
    bus_write(BASE | OFF_MODE, 64'd0);
    bus_write(BASE | OFF_INTR_EN, 64'd1);
    bus_write(BASE | OFF_OPSTART, 64'd1);
    wait_done(50, e);
    checks++; if (e !== 5) begin failures++; $display("FAIL f5_latency got=%0d exp=5", e); end
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL f5_intr got=%b exp=1", interrupt); end
    read_result(r);
    checks++; if (r !== 128'h78) begin failures++; $display("FAIL f5_result got=%h exp=78", r); end
    bus_read(BASE | OFF_STATUS, d);
    checks++; if (d !== 64'h1) begin failures++; $display("FAIL f5_status got=%h exp=1", d); end
    bus_write(BASE | OFF_INTR_EN, 64'd0);
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL f5_intr_off got=%b exp=0", interrupt); end
    bus_write(BASE | OFF_INTR_EN, 64'd1);
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL f5_intr_on got=%b exp=1", interrupt); end
  endtask

  task automatic test_small();
    logic [63:0] d;
    logic [127:0] r;
    int e;
    for (int n = 0; n < 2; n++) begin
      bus_write(BASE | OFF_OPERAND, 64'(n));
      bus_write(BASE | OFF_OPSTART, 64'd1);
      wait_done(20, e);
      checks++; if (e !== 1) begin failures++; $display("FAIL small%0d_latency got=%0d exp=1", n, e); end
      read_result(r);
      checks++; if (r !== 128'd1) begin failures++; $display("FAIL small%0d_result got=%h exp=1", n, r); end
      bus_read(BASE | OFF_STATUS, d);
      checks++; if (d !== 64'h1) begin failures++; $display("FAIL small%0d_status got=%h exp=1", n, d); end
    end
  endtask

  task automatic test_double();
    logic [127:0] r;
    int e;
    bus_write(BASE | OFF_MODE, 64'd1);
    bus_write(BASE | OFF_OPERAND, 64'd7);
    bus_write(BASE | OFF_OPSTART, 64'd1);
    wait_done(20, e);
    checks++; if (e !== 4) begin failures++; $display("FAIL dbl7_latency got=%0d exp=4", e); end
    read_result(r);
    checks++; if (r !== 128'd105) begin failures++; $display("FAIL dbl7_result got=%h exp=69", r); end
    bus_write(BASE | OFF_OPERAND, 64'd8);
    bus_write(BASE | OFF_OPSTART, 64'd1);
    wait_done(20, e);
    read_result(r);
    checks++; if (r !== 128'd384) begin failures++; $display("FAIL dbl8_result got=%h exp=180", r); end
    bus_write(BASE | OFF_MODE, 64'd0);
  endtask

  task automatic test_wide();
    logic [63:0]  d;
    logic [127:0] r, exp_r;
    logic [191:0] p;
    int e, exp_e;
    exp_r = 128'd1;
    for (int i = 2; i <= 34; i++) exp_r = exp_r * 128'(i);
    bus_write(BASE | OFF_OPERAND, 64'd34);
    bus_write(BASE | OFF_OPSTART, 64'd1);
    wait_done(60, e);
    read_result(r);
    checks++; if (r !== exp_r) begin failures++; $display("FAIL f34_result got=%h exp=%h", r, exp_r); end
    bus_read(BASE | OFF_STATUS, d);
    checks++; if (d !== 64'h1) begin failures++; $display("FAIL f34_status got=%h exp=1", d); end
    // Expected truncated value and done edge for 35!: stop on the first multiply that overflows.
    exp_r = 128'd1;
    exp_e = 0;
    for (int m = 35; m >= 2; m--) begin
      exp_e++;
      p = 192'(exp_r) * 192'(m);
      exp_r = p[127:0];
      if (p[191:128] != 64'd0) break;
    end
    bus_write(BASE | OFF_OPERAND, 64'd35);
    bus_write(BASE | OFF_OPSTART, 64'd1);
    wait_done(60, e);
    checks++; if (e !== exp_e) begin failures++; $display("FAIL f35_latency got=%0d exp=%0d", e, exp_e); end
    bus_read(BASE | OFF_STATUS, d);
    checks++; if (d !== 64'h5) begin failures++; $display("FAIL f35_status got=%h exp=5", d); end
    read_result(r);
    checks++; if (r !== exp_r) begin failures++; $display("FAIL f35_result got=%h exp=%h", r, exp_r); end
  endtask

  task automatic test_busy();
    logic [63:0]  d;
    logic [127:0] r, exp_r;
    int e;
    exp_r = 128'd1;
    for (int i = 2; i <= 20; i++) exp_r = exp_r * 128'(i);
    bus_write(BASE | OFF_OPERAND, 64'd20);
    bus_write(BASE | OFF_OPSTART, 64'd1);
    bus_read(BASE | OFF_STATUS, d);
    checks++; if (d !== 64'h2) begin failures++; $display("FAIL busy_status got=%h exp=2", d); end
    bus_write(BASE | OFF_OPSTART, 64'd1);
    bus_write(BASE | OFF_OPERAND, 64'd3);
    bus_write(BASE | OFF_MODE, 64'd1);
    wait_done(60, e);
    read_result(r);
    checks++; if (r !== exp_r) begin failures++; $display("FAIL busy_result got=%h exp=%h", r, exp_r); end
    bus_read(BASE | OFF_OPERAND, d);
    checks++; if (d !== 64'd20) begin failures++; $display("FAIL busy_operand got=%h exp=14", d); end
    bus_read(BASE | OFF_MODE, d);
    checks++; if (d !== 64'd0) begin failures++; $display("FAIL busy_mode got=%h exp=0", d); end
    bus_write(BASE | OFF_OPSTART, 64'd1);
    repeat (3) @(posedge clk);
    bus_write(BASE | OFF_OPCLEAR, 64'd1);
    bus_read(BASE | OFF_STATUS, d);
    checks++; if (d !== 64'h0) begin failures++; $display("FAIL clear_status got=%h exp=0", d); end
    read_result(r);
    checks++; if (r !== 128'd1) begin failures++; $display("FAIL clear_result got=%h exp=1", r); end
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL clear_intr got=%b exp=0", interrupt); end
    bus_read(BASE | OFF_INTR_EN, d);
    checks++; if (d !== 64'd1) begin failures++; $display("FAIL clear_intr_en got=%h exp=1", d); end
  endtask

  task automatic test_reset_mid();
    logic [63:0]  d;
    logic [127:0] r;
    int e;
    bus_write(BASE | OFF_OPSTART, 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    bus_read(BASE | OFF_STATUS, d);
    checks++; if (d !== 64'h0) begin failures++; $display("FAIL rmid_status got=%h exp=0", d); end
    bus_read(BASE | OFF_OPERAND, d);
    checks++; if (d !== 64'h0) begin failures++; $display("FAIL rmid_operand got=%h exp=0", d); end
    bus_read(BASE | OFF_INTR_EN, d);
    checks++; if (d !== 64'h0) begin failures++; $display("FAIL rmid_intr_en got=%h exp=0", d); end
    read_result(r);
    checks++; if (r !== 128'd1) begin failures++; $display("FAIL rmid_result got=%h exp=1", r); end
    bus_write(BASE | OFF_OPERAND, 64'd4);
    bus_write(BASE | OFF_OPSTART, 64'd1);
    wait_done(20, e);
    checks++; if (e !== 4) begin failures++; $display("FAIL rmid_f4_latency got=%0d exp=4", e); end
    read_result(r);
    checks++; if (r !== 128'h18) begin failures++; $display("FAIL rmid_f4_result got=%h exp=18", r); end
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL rmid_intr got=%b exp=0", interrupt); end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; s_sel = 1'b0; s_wr = 1'b0; s_addr = 16'd0; s_din = 64'd0;
    test_reset();
    test_map();
    test_fact5();
    test_small();
    test_double();
    test_wide();
    test_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
